mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives every datapath select and write enable, including the `signal` input of the immediate `extend` unit (1 = sign-extend, 0 = zero-extend). Memory accesses use a `mem_ready` handshake, so variable-latency memory stalls the sequence.

Parameters:
ILLEGAL_TRAP, 1, 1 = undefined opcode/funct pulses `illegal` and returns to FETCH; 0 = execute it as a NOP (no `illegal` pulse, `instr_done` pulses).

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]; stable from DECODE until instruction end
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
ext_sign  out  1  to extend.signal; 1 = sign, 0 = zero
pc_en  out  1  PC register write enable
pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
iord  out  1  0 = address from PC, 1 = from ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  out  1  one-cycle pulse in the final cycle of each completed instruction
illegal  out  1  one-cycle pulse in the ILLEGAL state

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
  - `reset` = 1 at a rising edge loads state = FETCH.
  - While `reset` is high, these outputs are forced to 0 combinationally: pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal.
  - During reset, all other outputs are 0, except ext_sign = 1 and alu_ctrl = 010.
  - Reset mid-instruction abandons the instruction; no partial write is issued after reset is seen.
- Output defaults: all outputs default to 0 except ext_sign = 1 and alu_ctrl = 010. Each state overrides only what it lists below.
- ext_sign:
  - FETCH and DECODE: 1.
  - All other states: 0 for andi (001100) and ori (001101), 1 otherwise.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010.
- R-type funct to alu_ctrl: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct is undefined.
- States and transitions:
  - FETCH: mem_read = 1, alu_src_b = 01, alu add. While mem_ready = 0, stay and keep pc_en = ir_write = 0. When mem_ready = 1, pc_en = 1, ir_write = 1, go to DECODE.
  - DECODE: alu_src_b = 11, add (branch target into ALUOut). Next state:
    - lw/sw → MEMADR
    - R with defined funct → EXECUTE
    - beq/bne → BRANCH
    - addi/andi/ori/slti → IEXEC
    - j → JUMP
    - anything else → ILLEGAL (ILLEGAL_TRAP = 1) or FETCH with instr_done (ILLEGAL_TRAP = 0)
  - MEMADR: alu_src_a = 1, alu_src_b = 10, add. lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: iord = 1, mem_read = 1. Stay until mem_ready = 1, then go to MEMWB.
  - MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1 → FETCH.
  - MEMWRITE: iord = 1, mem_write = 1. Stay until mem_ready = 1. That cycle asserts instr_done and goes to FETCH.
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_ctrl from funct → ALUWB.
  - ALUWB: reg_write = 1, reg_dst = 1, instr_done = 1 → FETCH.
  - IEXEC: alu_src_a = 1, alu_src_b = 10, alu_ctrl = 010/000/001/111 for addi/andi/ori/slti → IWB.
  - IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1 → FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_ctrl = 110, pc_src = 01. pc_en = zero for beq, ~zero for bne. instr_done = 1 → FETCH.
  - JUMP: pc_src = 10, pc_en = 1, instr_done = 1 → FETCH.
  - ILLEGAL: illegal = 1 → FETCH. instr_done is not asserted.
- Latency with mem_ready tied high: lw 5 cycles; R-type, I-ALU and sw 4; beq/bne/j 3; illegal 3.
- Each additional mem_ready = 0 cycle adds exactly one cycle.
- mem_read/mem_write stay asserted and address selects stay stable throughout a wait.
- Unused state encodings recover to FETCH on the next edge.
- State encoding: binary, 4 bits.

Test Plan:
- Reset, then lw with mem_ready = 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write = 1 and mem_to_reg = 1 only in cycle 5; instr_done pulses in cycle 5.
- andi then addi → ext_sign = 0 with alu_ctrl = 000 in IEXEC for andi; ext_sign = 1 with alu_ctrl = 010 for addi. Both take 4 cycles.
- beq with zero = 1 → pc_en = 1, pc_src = 01 in BRANCH. bne with zero = 1 → pc_en = 0; instr_done still pulses.
- mem_ready held 0 for 3 cycles in FETCH and in MEMWRITE → FETCH lasts 4 cycles with pc_en/ir_write only in the last. mem_write is asserted for 4 cycles; sw takes 7 cycles total.
- Reset asserted during the second MEMWRITE wait cycle → mem_write = 0 that cycle; next cycle FETCH with mem_read = 1 once reset is low.
- opcode 111111 with ILLEGAL_TRAP = 1 → illegal pulses 1 cycle in cycle 3, no reg_write/mem_write, no instr_done. R-type funct 000111 behaves the same.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// select and write enable. Memory accesses stall on the mem_ready handshake.
module mips_multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ext_sign,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_IEXEC    = 4'd8,
    S_IWB      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  state_t state_q, state_d;

  // Map an R-type funct to {defined, alu_ctrl}; undefined functs keep add.
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: r_alu = {1'b1, ALU_ADD};
      6'b100010: r_alu = {1'b1, ALU_SUB};
      6'b100100: r_alu = {1'b1, ALU_AND};
      6'b100101: r_alu = {1'b1, ALU_OR};
      6'b101010: r_alu = {1'b1, ALU_SLT};
      default:   r_alu = {1'b0, ALU_ADD};
    endcase
  endfunction

  logic       r_ok;
  logic [2:0] r_ctrl;
  logic [2:0] imm_ctrl;
  logic       is_logic_imm;
  logic       dec_ok;
  state_t     bad_target;

  assign {r_ok, r_ctrl} = r_alu(funct);
  assign is_logic_imm   = (opcode == OP_ANDI) || (opcode == OP_ORI);
  // An undefined instruction either traps or is retired from DECODE as a NOP.
  assign bad_target     = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;

  // Classify the opcode/funct pair and pick the immediate ALU operation.
  always_comb begin
    dec_ok   = 1'b0;
    imm_ctrl = ALU_ADD;
    case (opcode)
      OP_R:                        dec_ok = r_ok;
      OP_LW, OP_SW, OP_BEQ,
      OP_BNE, OP_ADDI, OP_J:       dec_ok = 1'b1;
      OP_ANDI: begin dec_ok = 1'b1; imm_ctrl = ALU_AND; end
      OP_ORI:  begin dec_ok = 1'b1; imm_ctrl = ALU_OR;  end
      OP_SLTI: begin dec_ok = 1'b1; imm_ctrl = ALU_SLT; end
      default:                     dec_ok = 1'b0;
    endcase
  end

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                        state_d = S_MEMADR;
          OP_R:                                state_d = r_ok ? S_EXECUTE : bad_target;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_IEXEC;
          OP_J:                                state_d = S_JUMP;
          default:                             state_d = bad_target;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_IEXEC:    state_d = S_IWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore outputs from the current state; reset forces every output to its default.
  always_comb begin
    ext_sign   = 1'b1;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      // Only andi/ori zero-extend, and only once the IR holds the new instruction.
      if (state_q != S_FETCH && state_q != S_DECODE) ext_sign = ~is_logic_imm;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_en     = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          instr_done = ~dec_ok & ~ILLEGAL_TRAP;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMREAD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_ctrl  = r_ctrl;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = imm_ctrl;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = ALU_SUB;
          pc_src     = 2'b01;
          pc_en      = (opcode == OP_BNE) ? ~zero : zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: each cycle's expected output
// vector is queued when the inputs are driven and compared at the falling edge.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       ext_sign;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  out_t       o;

  int n_tests = 0;
  int n_fail  = 0;
  out_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ext_sign(o.ext_sign), .pc_en(o.pc_en),
    .pc_src(o.pc_src), .iord(o.iord), .mem_read(o.mem_read),
    .mem_write(o.mem_write), .ir_write(o.ir_write), .reg_write(o.reg_write),
    .reg_dst(o.reg_dst), .mem_to_reg(o.mem_to_reg), .alu_src_a(o.alu_src_a),
    .alu_src_b(o.alu_src_b), .alu_ctrl(o.alu_ctrl),
    .instr_done(o.instr_done), .illegal(o.illegal)
  );

  // Expected vectors for each control state, written from the state table.
  function automatic out_t e_dflt();
    out_t e = '0;
    e.ext_sign = 1'b1;
    e.alu_ctrl = 3'b010;
    return e;
  endfunction
  function automatic out_t e_fetch(input logic mr);
    out_t e = e_dflt();
    e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.pc_en = mr; e.ir_write = mr;
    return e;
  endfunction
  function automatic out_t e_decode();
    out_t e = e_dflt();
    e.alu_src_b = 2'b11;
    return e;
  endfunction
  function automatic out_t e_memadr();
    out_t e = e_dflt();
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic out_t e_memread();
    out_t e = e_dflt();
    e.iord = 1'b1; e.mem_read = 1'b1;
    return e;
  endfunction
  function automatic out_t e_memwb();
    out_t e = e_dflt();
    e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic out_t e_memwrite(input logic mr);
    out_t e = e_dflt();
    e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = mr;
    return e;
  endfunction
  function automatic out_t e_exec(input logic [2:0] ac);
    out_t e = e_dflt();
    e.alu_src_a = 1'b1; e.alu_ctrl = ac;
    return e;
  endfunction
  function automatic out_t e_aluwb();
    out_t e = e_dflt();
    e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic out_t e_iexec(input logic es, input logic [2:0] ac);
    out_t e = e_dflt();
    e.ext_sign = es; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = ac;
    return e;
  endfunction
  function automatic out_t e_iwb(input logic es);
    out_t e = e_dflt();
    e.ext_sign = es; e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic out_t e_branch(input logic pe);
    out_t e = e_dflt();
    e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
    e.pc_en = pe; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic out_t e_jump();
    out_t e = e_dflt();
    e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic out_t e_illegal();
    out_t e = e_dflt();
    e.illegal = 1'b1;
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expectation, and check at the falling edge.
  task automatic step(input string tag, input logic rst, input logic mr,
                      input logic z, input logic [5:0] op, input logic [5:0] fn,
                      input out_t e);
    out_t  exp_v;
    string t;
    reset = rst; mem_ready = mr; zero = z; opcode = op; funct = fn;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    n_tests++;
    assert (o === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    step("reset",      1, 1, 0, OP_LW, 6'd0, e_dflt());

    // lw with memory always ready: 5 cycles
    step("lw_fetch",   0, 1, 0, OP_LW, 6'd0, e_fetch(1));
    step("lw_decode",  0, 1, 0, OP_LW, 6'd0, e_decode());
    step("lw_memadr",  0, 1, 0, OP_LW, 6'd0, e_memadr());
    step("lw_memread", 0, 1, 0, OP_LW, 6'd0, e_memread());
    step("lw_memwb",   0, 1, 0, OP_LW, 6'd0, e_memwb());

    // andi zero-extends, addi sign-extends
    step("andi_fetch", 0, 1, 0, OP_ANDI, 6'd0, e_fetch(1));
    step("andi_dec",   0, 1, 0, OP_ANDI, 6'd0, e_decode());
    step("andi_iexec", 0, 1, 0, OP_ANDI, 6'd0, e_iexec(0, 3'b000));
    step("andi_iwb",   0, 1, 0, OP_ANDI, 6'd0, e_iwb(0));
    step("addi_fetch", 0, 1, 0, OP_ADDI, 6'd0, e_fetch(1));
    step("addi_dec",   0, 1, 0, OP_ADDI, 6'd0, e_decode());
    step("addi_iexec", 0, 1, 0, OP_ADDI, 6'd0, e_iexec(1, 3'b010));
    step("addi_iwb",   0, 1, 0, OP_ADDI, 6'd0, e_iwb(1));

    // R-type sub and or
    step("sub_fetch",  0, 1, 0, OP_R, 6'b100010, e_fetch(1));
    step("sub_dec",    0, 1, 0, OP_R, 6'b100010, e_decode());
    step("sub_exec",   0, 1, 0, OP_R, 6'b100010, e_exec(3'b110));
    step("sub_wb",     0, 1, 0, OP_R, 6'b100010, e_aluwb());
    step("or_fetch",   0, 1, 0, OP_R, 6'b100101, e_fetch(1));
    step("or_dec",     0, 1, 0, OP_R, 6'b100101, e_decode());
    step("or_exec",    0, 1, 0, OP_R, 6'b100101, e_exec(3'b001));
    step("or_wb",      0, 1, 0, OP_R, 6'b100101, e_aluwb());

    // branches
    step("beq1_fetch", 0, 1, 1, OP_BEQ, 6'd0, e_fetch(1));
    step("beq1_dec",   0, 1, 1, OP_BEQ, 6'd0, e_decode());
    step("beq1_br",    0, 1, 1, OP_BEQ, 6'd0, e_branch(1));
    step("bne1_fetch", 0, 1, 1, OP_BNE, 6'd0, e_fetch(1));
    step("bne1_dec",   0, 1, 1, OP_BNE, 6'd0, e_decode());
    step("bne1_br",    0, 1, 1, OP_BNE, 6'd0, e_branch(0));
    step("beq0_fetch", 0, 1, 0, OP_BEQ, 6'd0, e_fetch(1));
    step("beq0_dec",   0, 1, 0, OP_BEQ, 6'd0, e_decode());
    step("beq0_br",    0, 1, 0, OP_BEQ, 6'd0, e_branch(0));
    step("bne0_fetch", 0, 1, 0, OP_BNE, 6'd0, e_fetch(1));
    step("bne0_dec",   0, 1, 0, OP_BNE, 6'd0, e_decode());
    step("bne0_br",    0, 1, 0, OP_BNE, 6'd0, e_branch(1));

    // jump
    step("j_fetch",    0, 1, 0, OP_J, 6'd0, e_fetch(1));
    step("j_dec",      0, 1, 0, OP_J, 6'd0, e_decode());
    step("j_jump",     0, 1, 0, OP_J, 6'd0, e_jump());

    // ori with FETCH stalled 3 cycles
    for (int i = 0; i < 3; i++)
      step("ori_fetch_wait", 0, 0, 0, OP_ORI, 6'd0, e_fetch(0));
    step("ori_fetch",  0, 1, 0, OP_ORI, 6'd0, e_fetch(1));
    step("ori_dec",    0, 1, 0, OP_ORI, 6'd0, e_decode());
    step("ori_iexec",  0, 1, 0, OP_ORI, 6'd0, e_iexec(0, 3'b001));
    step("ori_iwb",    0, 1, 0, OP_ORI, 6'd0, e_iwb(0));

    // sw with MEMWRITE stalled 3 cycles: 7 cycles total
    step("sw_fetch",   0, 1, 0, OP_SW, 6'd0, e_fetch(1));
    step("sw_dec",     0, 1, 0, OP_SW, 6'd0, e_decode());
    step("sw_memadr",  0, 1, 0, OP_SW, 6'd0, e_memadr());
    for (int i = 0; i < 3; i++)
      step("sw_wr_wait", 0, 0, 0, OP_SW, 6'd0, e_memwrite(0));
    step("sw_wr_done", 0, 1, 0, OP_SW, 6'd0, e_memwrite(1));

    // lw with MEMREAD stalled 1 cycle
    step("lw2_fetch",  0, 1, 0, OP_LW, 6'd0, e_fetch(1));
    step("lw2_dec",    0, 1, 0, OP_LW, 6'd0, e_decode());
    step("lw2_memadr", 0, 1, 0, OP_LW, 6'd0, e_memadr());
    step("lw2_rd_wait",0, 0, 0, OP_LW, 6'd0, e_memread());
    step("lw2_rd",     0, 1, 0, OP_LW, 6'd0, e_memread());
    step("lw2_memwb",  0, 1, 0, OP_LW, 6'd0, e_memwb());

    // reset during the second MEMWRITE wait cycle
    step("swr_fetch",  0, 1, 0, OP_SW, 6'd0, e_fetch(1));
    step("swr_dec",    0, 1, 0, OP_SW, 6'd0, e_decode());
    step("swr_memadr", 0, 1, 0, OP_SW, 6'd0, e_memadr());
    step("swr_wait1",  0, 0, 0, OP_SW, 6'd0, e_memwrite(0));
    step("swr_reset",  1, 0, 0, OP_SW, 6'd0, e_dflt());
    step("swr_refetch",0, 1, 0, OP_BAD, 6'd0, e_fetch(1));

    // undefined opcode and undefined funct trap
    step("bad_dec",    0, 1, 0, OP_BAD, 6'd0, e_decode());
    step("bad_illegal",0, 1, 0, OP_BAD, 6'd0, e_illegal());
    step("badfn_fetch",0, 1, 0, OP_R, 6'b000111, e_fetch(1));
    step("badfn_dec",  0, 1, 0, OP_R, 6'b000111, e_decode());
    step("badfn_ill",  0, 1, 0, OP_R, 6'b000111, e_illegal());

    // slti after the trap resumes normally
    step("slti_fetch", 0, 1, 0, OP_SLTI, 6'd0, e_fetch(1));
    step("slti_dec",   0, 1, 0, OP_SLTI, 6'd0, e_decode());
    step("slti_iexec", 0, 1, 0, OP_SLTI, 6'd0, e_iexec(1, 3'b111));
    step("slti_iwb",   0, 1, 0, OP_SLTI, 6'd0, e_iwb(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
